// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit that owns the HI/LO register pair.
// Multiply-class ops keep Busy high for MULT_LAT cycles and divides for DIV_LAT cycles.
// Results are written on the edge that ends the busy period.
// mthi/mtlo write HI or LO directly in one cycle.
module mdu_unit #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int OP_LEN   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic [OP_LEN-1:0] MDUOp,
    input  logic [31:0]       A,
    input  logic [31:0]       B,
    output logic              Busy,
    output logic [31:0]       HI,
    output logic [31:0]       LO
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [OP_LEN-1:0] OP_MULT  = OP_LEN'(1);
    localparam logic [OP_LEN-1:0] OP_MULTU = OP_LEN'(2);
    localparam logic [OP_LEN-1:0] OP_DIV   = OP_LEN'(3);
    localparam logic [OP_LEN-1:0] OP_DIVU  = OP_LEN'(4);
    localparam logic [OP_LEN-1:0] OP_MADD  = OP_LEN'(5);
    localparam logic [OP_LEN-1:0] OP_MADDU = OP_LEN'(6);
    localparam logic [OP_LEN-1:0] OP_MSUB  = OP_LEN'(7);
    localparam logic [OP_LEN-1:0] OP_MSUBU = OP_LEN'(8);
    localparam logic [OP_LEN-1:0] OP_MTHI  = OP_LEN'(9);
    localparam logic [OP_LEN-1:0] OP_MTLO  = OP_LEN'(10);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   start_lat;
    logic [OP_LEN-1:0]  op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [63:0]        acc_q;
    logic               is_multi;
    logic               last_cycle;
    logic               accept;
    logic               finish_wr;
    logic [63:0]        result;
    logic               result_wr;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] sdvd;
    logic signed [31:0] sdvs;
    logic signed [31:0] squo;
    logic signed [31:0] srem;
    logic [31:0]        udvs;
    logic [31:0]        uquo;
    logic [31:0]        urem;

    // A request may be taken from IDLE or on the final busy edge, so back-to-back ops leave no gap.
    assign is_multi   = Start && (MDUOp >= OP_MULT) && (MDUOp <= OP_MSUBU);
    assign last_cycle = (state == RUN) && (cnt == CNT_W'(1));
    assign accept     = is_multi && ((state == IDLE) || last_cycle);
    assign finish_wr  = last_cycle && result_wr;
    assign start_lat  = ((MDUOp == OP_DIV) || (MDUOp == OP_DIVU)) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    assign Busy       = (state == RUN);

    // Sign/zero-extended 64-bit operands: the low 64 bits of the product are exact in both cases.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Divisor forced to 1 for x/0 (result discarded) and for MIN/-1, where MIN/1 gives the wrapped answer.
    assign sdvd = a_q;
    assign sdvs = ((b_q == 32'd0) || ((a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF))) ? 32'sd1 : b_q;
    assign squo = sdvd / sdvs;
    assign srem = sdvd % sdvs;
    assign udvs = (b_q == 32'd0) ? 32'd1 : b_q;
    assign uquo = a_q / udvs;
    assign urem = a_q % udvs;

    // Select the {HI,LO} value for the latched op; divides by zero suppress the write.
    always_comb begin
        result    = acc_q;
        result_wr = 1'b1;
        case (op_q)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_MADD:  result = acc_q + prod_s;
            OP_MADDU: result = acc_q + prod_u;
            OP_MSUB:  result = acc_q - prod_s;
            OP_MSUBU: result = acc_q - prod_u;
            OP_DIV: begin
                if (b_q == 32'd0) result_wr = 1'b0;
                else              result    = {srem, squo};
            end
            OP_DIVU: begin
                if (b_q == 32'd0) result_wr = 1'b0;
                else              result    = {urem, uquo};
            end
            default: result_wr = 1'b0;
        endcase
    end

    // Next-state and counter: reload on accept, otherwise count down and return to IDLE at 1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                    cnt_next   = start_lat;
                end
            end
            RUN: begin
                if (accept) begin
                    state_next = RUN;
                    cnt_next   = start_lat;
                end else if (last_cycle) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter and operand latch; a chained op latches the result being written this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                op_q  <= MDUOp;
                a_q   <= A;
                b_q   <= B;
                acc_q <= finish_wr ? result : {HI, LO};
            end
        end
    end

    // HI/LO update: completed op results, or direct moves while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            HI <= '0;
            LO <= '0;
        end else if (finish_wr) begin
            HI <= result[63:32];
            LO <= result[31:0];
        end else if ((state == IDLE) && Start && (MDUOp == OP_MTHI)) begin
            HI <= A;
        end else if ((state == IDLE) && Start && (MDUOp == OP_MTLO)) begin
            LO <= A;
        end
    end

endmodule
